// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port among NUM_REQ requesters.
// Define BRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module bram_port_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTE   = 4,
  parameter int RD_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_idat,
  input  logic [NUM_REQ-1:0]            req_rden,
  input  logic [NUM_REQ-1:0]            req_wren,
  output logic [NUM_REQ-1:0]            req_gnt,
  output logic [DATA_WIDTH-1:0]         req_odat,
  output logic [NUM_REQ-1:0]            req_oval,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_idat,
  input  logic [DATA_WIDTH-1:0]         mem_odat,
  output logic [NUM_BYTE-1:0]           mem_wren,
  output logic                          mem_enb,
  output logic                          mem_rst
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    act;
  logic [IW-1:0]         win_d;
  logic                  hit_d;
  logic                  wr_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] idat_d;

  logic                  enb_q;
  logic [NUM_BYTE-1:0]   wren_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] idat_q;
  logic [NUM_REQ-1:0]    gnt_q;
  logic [NUM_REQ-1:0]    tag_q [RD_LATENCY];

  assign act = req_rden | req_wren;

`ifdef BRAM_ARB_FIXED_PRIO_EN
  always_comb begin
    win_d = '0;
    hit_d = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (act[k]) begin
        hit_d = 1'b1;
        win_d = IW'(k);
      end
    end
    if (rst) hit_d = 1'b0;
  end
`else
  logic [IW-1:0] last_q;
  logic [IW-1:0] rr_idx;

  // Search starts just past the last winner and wraps.
  always_comb begin
    win_d  = '0;
    hit_d  = 1'b0;
    rr_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx = IW'((int'(last_q) + k) % NUM_REQ);
      if (!hit_d && act[rr_idx]) begin
        hit_d = 1'b1;
        win_d = rr_idx;
      end
    end
    if (rst) hit_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= IW'(NUM_REQ - 1);
    else if (hit_d) last_q <= win_d;
  end
`endif

  // A write takes precedence; a held rden waits for a later grant.
  always_comb begin
    req_gnt = '0;
    if (hit_d) req_gnt[win_d] = 1'b1;
    wr_d   = req_wren[win_d];
    addr_d = req_addr[int'(win_d)*ADDR_WIDTH +: ADDR_WIDTH];
    idat_d = req_idat[int'(win_d)*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enb_q  <= 1'b0;
      wren_q <= '0;
      addr_q <= '0;
      idat_q <= '0;
      gnt_q  <= '0;
      for (int k = 0; k < RD_LATENCY; k++) tag_q[k] <= '0;
    end else begin
      enb_q  <= hit_d;
      wren_q <= {NUM_BYTE{hit_d & wr_d}};
      gnt_q  <= req_gnt;
      if (hit_d) begin
        addr_q <= addr_d;
        idat_q <= idat_d;
      end
      tag_q[0] <= (enb_q && wren_q == '0) ? gnt_q : '0;
      for (int k = 1; k < RD_LATENCY; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign req_oval = tag_q[RD_LATENCY-1];
  assign req_odat = mem_odat;
  assign mem_addr = addr_q;
  assign mem_idat = idat_q;
  assign mem_wren = wren_q;
  assign mem_enb  = enb_q;
  assign mem_rst  = rst;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomized scoreboard bench for bram_port_arbiter with a BRAM model.
module tb_bram_port_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int RL = 2;
  localparam int NCYC = 2500;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_idat = '0;
  logic [N-1:0]    req_rden = '0;
  logic [N-1:0]    req_wren = '0;
  logic [N-1:0]    req_gnt;
  logic [DW-1:0]   req_odat;
  logic [N-1:0]    req_oval;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_idat;
  logic [DW-1:0]   mem_odat;
  logic [NB-1:0]   mem_wren;
  logic            mem_enb;
  logic            mem_rst;

  bram_port_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .NUM_BYTE(NB), .RD_LATENCY(RL)
  ) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_idat(req_idat),
    .req_rden(req_rden), .req_wren(req_wren),
    .req_gnt(req_gnt), .req_odat(req_odat), .req_oval(req_oval),
    .mem_addr(mem_addr), .mem_idat(mem_idat), .mem_odat(mem_odat),
    .mem_wren(mem_wren), .mem_enb(mem_enb), .mem_rst(mem_rst)
  );

  typedef struct {
    int          who;
    int          due;
    logic [DW-1:0] data;
  } rd_t;

  typedef struct {
    int          due;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
    logic        wr;
  } op_t;

  rd_t rdq[$];
  op_t opq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  function automatic logic [DW-1:0] seed(int i);
    return DW'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: fixed RL-cycle read latency, full-word writes.
  logic [DW-1:0] bram [16];
  logic [DW-1:0] pipe [RL];
  logic          seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 16; i++) bram[i] <= seed(i);
      seeded <= 1'b1;
    end else if (mem_enb && mem_wren == 4'hF) begin
      bram[mem_addr[3:0]] <= mem_idat;
    end
    pipe[0] <= (mem_enb && mem_wren == '0) ? bram[mem_addr[3:0]] : 32'hBAD0_BAD0;
    for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
  end
  assign mem_odat = pipe[RL-1];

  // Monitor: pops expected responses whenever the DUT presents them.
  logic [AW-1:0] last_addr = '0;
  always @(negedge clk) begin
    rd_t r;
    op_t o;
    if (rdq.size() > 0 && rdq[0].due < cyc) begin
      r = rdq.pop_front();
      chk("oval_missing", 64'(req_oval), 64'(1 << r.who));
    end
    if (req_oval != '0) begin
      if (rdq.size() == 0) begin
        chk("oval_unexpected", 64'(req_oval), 64'd0);
      end else begin
        r = rdq.pop_front();
        chk("oval_who", 64'(req_oval), 64'(1 << r.who));
        chk("oval_cyc", 64'(cyc), 64'(r.due));
        chk("odat", 64'(req_odat), 64'(r.data));
      end
    end
    if (opq.size() > 0 && opq[0].due < cyc) begin
      o = opq.pop_front();
      chk("enb_missing", 64'(mem_enb), 64'd1);
    end
    if (mem_enb) begin
      if (opq.size() == 0) begin
        chk("enb_unexpected", 64'(mem_enb), 64'd0);
      end else begin
        o = opq.pop_front();
        chk("op_cyc", 64'(cyc), 64'(o.due));
        chk("mem_addr", 64'(mem_addr), 64'(o.addr));
        chk("mem_wren", 64'(mem_wren), o.wr ? 64'hF : 64'h0);
        if (o.wr) chk("mem_idat", 64'(mem_idat), 64'(o.dat));
        last_addr = o.addr;
      end
    end else begin
      chk("idle_wren", 64'(mem_wren), 64'd0);
      chk("hold_addr", 64'(mem_addr), 64'(last_addr));
    end
    chk("mem_rst", 64'(mem_rst), 64'(rst));
    if (rst) last_addr = '0;
  end

  // Requester-side state and reference arbitration.
  logic          drv_rd [N];
  logic          drv_wr [N];
  logic [AW-1:0] drv_a  [N];
  logic [DW-1:0] drv_d  [N];
  logic [DW-1:0] ref_mem [16];
  int            last;
  int            w;
  bit            all_rd;
  bit            quiet;

  function automatic int pick(logic [N-1:0] a, int l);
`ifdef BRAM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (a[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (a[(l + k) % N]) return (l + k) % N;
`endif
    return -1;
  endfunction

  task automatic new_req(int i);
    int r;
    r = int'($urandom_range(0, 9));
    drv_a[i] = AW'($urandom_range(0, 15));
    drv_d[i] = $urandom;
    if (quiet) r = 0;
    if (all_rd) r = 4;
    drv_rd[i] = (r >= 4 && r <= 6) || r == 9;
    drv_wr[i] = (r >= 7);
  endtask

  initial begin
    logic [N-1:0] a;
    for (int i = 0; i < 16; i++) ref_mem[i] = seed(i);
    for (int i = 0; i < N; i++) begin
      drv_rd[i] = 1'b0; drv_wr[i] = 1'b0;
      drv_a[i] = '0; drv_d[i] = '0;
    end
    last = N - 1;
    w = -1;
    all_rd = 1'b0;
    quiet = 1'b0;
    for (int c = 0; c < NCYC + 12; c++) begin
      @(posedge clk);
      #1;
      all_rd = (c >= 10 && c < 22);
      quiet = (c >= NCYC);
      if (w >= 0) begin
        if (drv_wr[w] && drv_rd[w]) drv_wr[w] = 1'b0;
        else new_req(w);
      end
      for (int i = 0; i < N; i++)
        if (i != w && !drv_rd[i] && !drv_wr[i] && $urandom_range(0, 2) == 0)
          new_req(i);
      if (all_rd)
        for (int i = 0; i < N; i++) begin
          drv_rd[i] = 1'b1; drv_wr[i] = 1'b0;
        end
      rst = (c < 3) || c == 700 || c == 1500 || c == 1501;
      for (int i = 0; i < N; i++) begin
        req_rden[i] = drv_rd[i];
        req_wren[i] = drv_wr[i];
        req_addr[i*AW +: AW] = drv_a[i];
        req_idat[i*DW +: DW] = drv_d[i];
      end
      @(negedge clk);
      for (int i = 0; i < N; i++) a[i] = drv_rd[i] | drv_wr[i];
      w = -1;
      if (c == 1) begin
        chk("rst_oval", 64'(req_oval), 64'd0);
        chk("rst_enb", 64'(mem_enb), 64'd0);
        chk("rst_wren", 64'(mem_wren), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_idat", 64'(mem_idat), 64'd0);
      end
      if (rst) begin
        chk("rst_gnt", 64'(req_gnt), 64'd0);
        while (rdq.size() > 0 && rdq[rdq.size()-1].due > cyc) void'(rdq.pop_back());
        while (opq.size() > 0 && opq[opq.size()-1].due > cyc) void'(opq.pop_back());
        last = N - 1;
      end else begin
        w = pick(a, last);
        chk("gnt", 64'(req_gnt), w < 0 ? 64'd0 : 64'(1 << w));
        if (w >= 0) begin
          op_t o;
          last = w;
          o.due = cyc + 1;
          o.addr = drv_a[w];
          o.dat = drv_d[w];
          o.wr = drv_wr[w];
          opq.push_back(o);
          if (drv_wr[w]) begin
            ref_mem[drv_a[w][3:0]] = drv_d[w];
          end else begin
            rd_t r;
            r.who = w;
            r.due = cyc + 1 + RL;
            r.data = ref_mem[drv_a[w][3:0]];
            rdq.push_back(r);
          end
        end
      end
    end
    @(negedge clk);
    chk("rdq_drained", 64'(rdq.size()), 64'd0);
    chk("opq_drained", 64'(opq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one physical BRAM port (mem_* bus, bram_ctrl-compatible) between NUM_REQ requesters, e.g. psum accumulation read, psum write-back and host result readout.
- Round-robin arbitration, one access per cycle; registered memory-side outputs.
- Tracks in-flight reads through a tag pipeline so read data returns to the requester that issued it.
- Sits between accelerator_core / readout logic and the dnn_accelerator_core mem_*_N ports.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- NUM_BYTE, 4, byte-enable width (DATA_WIDTH/8)
- RD_LATENCY, 2, cycles from mem_enb (read) to valid mem_odat (1..4)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester address, requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_idat  in  NUM_REQ*DATA_WIDTH  per-requester write data
- req_rden  in  NUM_REQ  read request, level, held until granted
- req_wren  in  NUM_REQ  write request, level, held until granted
- req_gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as request
- req_odat  out  DATA_WIDTH  read data, broadcast to all requesters
- req_oval  out  NUM_REQ  one-hot read-data valid, per requester
- mem_addr  out  ADDR_WIDTH  BRAM address
- mem_idat  out  DATA_WIDTH  BRAM write data
- mem_odat  in  DATA_WIDTH  BRAM read data
- mem_wren  out  NUM_BYTE  BRAM byte write enables
- mem_enb  out  1  BRAM enable
- mem_rst  out  1  BRAM reset, equals rst

Behaviour:
- Request and grant:
  - Requester i is active when req_rden[i] | req_wren[i].
  - At most one req_gnt bit is set per cycle, and only for an active requester.
  - A requester deasserts its request, or presents the next one, in the cycle after it sees gnt.
- Round-robin:
  - Register last_gnt holds the index of the last grant; reset value NUM_REQ-1, so requester 0 has priority first.
  - Search order is last_gnt+1, last_gnt+2, … modulo NUM_REQ.
  - last_gnt updates only on a grant.
  - Any active requester is granted within NUM_REQ cycles.
- Read and write both set (same requester): the write is serviced and the read is ignored that cycle; the requester keeps rden held for a later grant.
- Memory side, registered, 1 cycle after grant:
  - mem_enb = 1.
  - mem_addr and mem_idat = the winner's values.
  - mem_wren = all ones for a write, 0 for a read.
  - With no grant: mem_enb = 0, mem_wren = 0, mem_addr/mem_idat hold their previous values.
- Read return:
  - A one-hot tag shift register of depth RD_LATENCY is loaded with the winner's one-hot when mem_enb issues a read, and with 0 otherwise.
  - req_oval = tag at the pipeline tail; req_odat = mem_odat, combinational pass-through.
  - Total latency, gnt to oval = 1 + RD_LATENCY cycles. Reads are returned in order. Writes produce no oval.
- Throughput: back-to-back reads from different requesters every cycle; no bubbles.
- Reset values: req_gnt 0, req_oval 0, mem_enb 0, mem_wren 0, mem_addr 0, mem_idat 0, tag pipeline 0, last_gnt NUM_REQ-1.
- Reset mid-operation: in-flight tags are cleared and no req_oval is issued for reads started before reset. During rst, req_gnt = 0 even if requests are active.
- Width rule: the write data path is the full DATA_WIDTH word; there are no partial-byte writes.

Optional Feature:
- Macro BRAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; last_gnt is removed; starvation is permitted and is the caller's responsibility.
- Undefined (default): round-robin as described above.
- Latency, tag pipeline and reset behaviour are identical in both modes.

Test Plan:
- Single read: req_rden[0]=1, addr 0x10 at cycle 0; BRAM returns 0xDEADBEEF → gnt[0] at cycle 0, mem_enb=1 with mem_addr=0x10 at cycle 1, req_oval=3'b001 and req_odat=0xDEADBEEF at cycle 3 (RD_LATENCY=2).
- Single write: req_wren[1]=1, addr 0x20, data 0x12345678 → cycle 1: mem_wren=4'hF, mem_idat=0x12345678, mem_addr=0x20; req_oval stays 0 throughout.
- Round-robin: all three requesters hold rden for 6 cycles → gnt sequence 0,1,2,0,1,2; req_oval sequence 001,010,100,… from cycle 3, one per cycle with no gaps.
- Read+write same requester: req_rden[2]=req_wren[2]=1 with no other requester → first grant is a write (mem_wren=4'hF); rden still held → next grant to 2 is a read and returns oval 3 cycles later.
- Reset mid-flight: issue reads at cycles 0 and 1, assert rst at cycle 2 for 1 cycle → req_oval stays 0 through cycle 6, mem_enb=0 at cycle 3, and the first grant after reset goes to requester 0.
- With BRAM_ARB_FIXED_PRIO_EN defined: requesters 0 and 2 hold rden continuously → gnt[0] every cycle and gnt[2] never.
